// File: rtl/rom_rd_arbiter.sv
// Round-robin read arbiter sharing one single-port template ROM among NUM_REQ requesters.
// Latency: grant in t, rom_addr in t+1, rd_valid/rd_data in t+1+ROM_LATENCY; one read per cycle.
// Backpressure: requesters hold req/addr until gnt; returned data has no stall path.
module rom_rd_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 32,
    parameter int ROM_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [ADDR_WIDTH-1:0]         rom_addr,
    input  logic [DATA_WIDTH-1:0]         rom_rd_data,
    output logic [NUM_REQ-1:0]            rd_valid,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          busy,
    output logic                          rom_clk_en,
    output logic                          rom_addr_strobe,
    output logic                          rom_rd_oce,
    output logic                          rom_rst
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
    logic [PTR_W-1:0]      cand;
    logic [PTR_W-1:0]      win_idx;
    logic                  win_vld;

    logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
    logic                  issue_v_q, issue_v_d;
    logic [PTR_W-1:0]      issue_id_q, issue_id_d;
    logic [NUM_REQ-1:0]    issue_oh;

    // Each tag stage holds the one-hot owner of the read at that depth (all-zero = empty).
    logic [NUM_REQ-1:0]    tag_q [ROM_LATENCY];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_addr
            assign addr_arr[gi] = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        end
    endgenerate

    // Walk upward from ptr; the first requester found wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = PTR_W'((int'(ptr_q) + i) % NUM_REQ);
            if (!win_vld && req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    assign gnt = win_vld ? (NUM_REQ'(1) << win_idx) : '0;

    always_comb begin
        ptr_d      = ptr_q;
        rom_addr_d = rom_addr_q;
        issue_v_d  = 1'b0;
        issue_id_d = issue_id_q;
        if (win_vld) begin
            ptr_d      = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            rom_addr_d = addr_arr[win_idx];
            issue_v_d  = 1'b1;
            issue_id_d = win_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            rom_addr_q <= '0;
            issue_v_q  <= 1'b0;
            issue_id_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            rom_addr_q <= rom_addr_d;
            issue_v_q  <= issue_v_d;
            issue_id_q <= issue_id_d;
        end
    end

    assign issue_oh = issue_v_q ? (NUM_REQ'(1) << issue_id_q) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < ROM_LATENCY; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            tag_q[0] <= issue_oh;
            for (int s = 1; s < ROM_LATENCY; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    always_comb begin
        busy = issue_v_q;
        for (int s = 0; s < ROM_LATENCY; s++) begin
            busy = busy | (|tag_q[s]);
        end
    end

    assign rom_addr        = rom_addr_q;
    assign rd_valid        = tag_q[ROM_LATENCY-1];
    assign rd_data         = rom_rd_data;
    assign rom_clk_en      = 1'b1;
    assign rom_addr_strobe = 1'b1;
    assign rom_rd_oce      = 1'b1;
    assign rom_rst         = ~rst_n;

endmodule

// File: tb/tb_rom_rd_arbiter.sv
// Drives two arbiters (ROM latency 1 and 2) with shared stimulus and checks both
// against a cycle-indexed grant history model; ROM contents are addr + 0x1000.
module tb_rom_rd_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 10;
    localparam int DW   = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NREQ-1:0] req;
    logic [NREQ*AW-1:0] req_addr;

    logic [NREQ-1:0] gnt_a, gnt_b, rdv_a, rdv_b;
    logic [AW-1:0]   rom_addr_a, rom_addr_b;
    logic [DW-1:0]   rom_data_a, rom_data_b, rd_data_a, rd_data_b, rom_b_q0;
    logic            busy_a, busy_b;
    logic            cen_a, stb_a, oce_a, rrst_a, cen_b, stb_b, oce_b, rrst_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 16;

    int              m_ptr;
    logic [AW-1:0]   m_rom_addr;
    bit              hist_v [16];
    int              hist_id [16];
    logic [AW-1:0]   hist_addr [16];
    int              last_win;
    bit              plan_en;
    logic [NREQ-1:0] plan_gnt;

    always #5 clk = ~clk;

    rom_rd_arbiter #(.NUM_REQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .gnt(gnt_a),
        .rom_addr(rom_addr_a), .rom_rd_data(rom_data_a), .rd_valid(rdv_a), .rd_data(rd_data_a),
        .busy(busy_a), .rom_clk_en(cen_a), .rom_addr_strobe(stb_a), .rom_rd_oce(oce_a), .rom_rst(rrst_a)
    );

    rom_rd_arbiter #(.NUM_REQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_LATENCY(2)) u_dut_l2 (
        .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .gnt(gnt_b),
        .rom_addr(rom_addr_b), .rom_rd_data(rom_data_b), .rd_valid(rdv_b), .rd_data(rd_data_b),
        .busy(busy_b), .rom_clk_en(cen_b), .rom_addr_strobe(stb_b), .rom_rd_oce(oce_b), .rom_rst(rrst_b)
    );

    // ROM behaviour: registered read, optionally with the output register.
    always @(posedge clk) begin
        rom_data_a <= {22'd0, rom_addr_a} + 32'h1000;
        rom_b_q0   <= {22'd0, rom_addr_b} + 32'h1000;
        rom_data_b <= rom_b_q0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        m_ptr      = 0;
        m_rom_addr = '0;
        for (int i = 0; i < 16; i++) begin
            hist_v[i]    = 1'b0;
            hist_id[i]   = 0;
            hist_addr[i] = '0;
        end
    endtask

    task automatic check_lane(input string nm, input int lat, input logic [NREQ-1:0] rdv,
                              input logic [DW-1:0] rdd, input logic bsy);
        int g;
        logic [NREQ-1:0] ev;
        bit eb;
        g  = (cyc - 1 - lat) % 16;
        ev = hist_v[g] ? (NREQ'(1) << hist_id[g]) : '0;
        chk({nm, "_rd_valid"}, 32'(rdv), 32'(ev));
        if (hist_v[g]) chk({nm, "_rd_data"}, rdd, {22'd0, hist_addr[g]} + 32'h1000);
        eb = 1'b0;
        for (int d = 1; d <= lat + 1; d++) begin
            if (hist_v[(cyc - d) % 16]) eb = 1'b1;
        end
        chk({nm, "_busy"}, 32'(bsy), 32'(eb));
    endtask

    task automatic sample();
        int win;
        int k;
        logic [1:0] ki;
        logic [NREQ-1:0] exp_gnt;
        win = -1;
        for (int i = 0; i < NREQ; i++) begin
            k  = (m_ptr + i) % NREQ;
            ki = 2'(k);
            if (win < 0 && req[ki]) win = k;
        end
        exp_gnt = (win >= 0) ? (NREQ'(1) << win) : '0;
        chk("gnt_l1", 32'(gnt_a), 32'(exp_gnt));
        chk("gnt_l2", 32'(gnt_b), 32'(exp_gnt));
        if (plan_en) chk("plan_gnt", 32'(gnt_a), 32'(plan_gnt));
        chk("rom_addr_l1", 32'(rom_addr_a), 32'(m_rom_addr));
        chk("rom_addr_l2", 32'(rom_addr_b), 32'(m_rom_addr));
        check_lane("l1", 1, rdv_a, rd_data_a, busy_a);
        check_lane("l2", 2, rdv_b, rd_data_b, busy_b);
        if (!rst_n) win = -1;
        hist_v[cyc % 16] = (win >= 0);
        if (win >= 0) begin
            hist_id[cyc % 16]   = win;
            hist_addr[cyc % 16] = req_addr[win*AW +: AW];
            m_rom_addr          = req_addr[win*AW +: AW];
            m_ptr               = (win + 1) % NREQ;
        end
        last_win = win;
    endtask

    task automatic cycle();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic planned(input logic [NREQ-1:0] r, input logic [NREQ-1:0] g);
        req      = r;
        plan_gnt = g;
        plan_en  = 1'b1;
        cycle();
        plan_en  = 1'b0;
    endtask

    task automatic idle(input int n);
        req = '0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        rst_n    = 1'b0;
        req      = '0;
        req_addr = '0;
        plan_en  = 1'b0;
        plan_gnt = '0;
        last_win = -1;
        model_clear();
        #2;
        chk("reset_rom_addr", 32'(rom_addr_a), 32'd0);
        chk("reset_rd_valid", 32'(rdv_b), 32'd0);
        chk("reset_busy", 32'(busy_b), 32'd0);
        chk("reset_gnt", 32'(gnt_a), 32'd0);
        chk("reset_rom_rst", 32'(rrst_a), 32'd1);
        chk("rom_ties", 32'({cen_a, stb_a, oce_b}), 32'd7);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // All requesters from reset: strict 0,1,2,3 rotation.
        for (int k = 0; k < NREQ; k++) req_addr[k*AW +: AW] = AW'($urandom);
        for (int i = 0; i < 8; i++) begin
            planned(4'b1111, NREQ'(1) << (i % 4));
            if (last_win >= 0) req_addr[last_win*AW +: AW] = AW'($urandom);
        end
        idle(5);

        // Single requester streaming addresses 0x10..0x17.
        for (int i = 0; i < 8; i++) begin
            req_addr[2*AW +: AW] = AW'(32'h10 + i);
            planned(4'b0100, 4'b0100);
        end
        idle(5);

        // Wrap-around fairness: 3 then {0,3} alternating.
        planned(4'b1000, 4'b1000);
        planned(4'b1001, 4'b0001);
        planned(4'b1001, 4'b1000);
        planned(4'b1001, 4'b0001);
        idle(4);

        // Withdrawal: requester 1 drops before its turn.
        planned(4'b1000, 4'b1000);
        planned(4'b0011, 4'b0001);
        planned(4'b0000, 4'b0000);
        idle(4);

        // Isolated grant to observe busy window per latency.
        planned(4'b0001, 4'b0001);
        idle(6);

        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < NREQ; k++) req[k] = ($urandom_range(0, 99) < 55);
            cycle();
            if (last_win >= 0) req_addr[last_win*AW +: AW] = AW'($urandom);
        end
        idle(5);

        // Reset with three reads in flight.
        req = 4'b1111;
        for (int i = 0; i < 3; i++) cycle();
        req = '0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_rom_addr_l1", 32'(rom_addr_a), 32'd0);
        chk("midrst_rom_addr_l2", 32'(rom_addr_b), 32'd0);
        chk("midrst_rd_valid_l1", 32'(rdv_a), 32'd0);
        chk("midrst_rd_valid_l2", 32'(rdv_b), 32'd0);
        chk("midrst_busy_l1", 32'(busy_a), 32'd0);
        chk("midrst_busy_l2", 32'(busy_b), 32'd0);
        chk("midrst_rom_rst", 32'(rrst_b), 32'd1);
        model_clear();
        cycle();
        cycle();
        rst_n = 1'b1;
        idle(8);
        chk("post_rst_rom_rst", 32'(rrst_b), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
